// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- instruction-fetch stage feeding the data/execute datapath.
//
// The host loads an instruction memory while the micro is idle. A start pulse
// streams instructions from address 0 to the downstream stage through a
// registered output (instr_if/ins_valid) that honours the halt_if stall.
// Streaming stops at an END opcode or after the last memory address. Once the
// stream has fully drained, the block waits for the execute unit (run_ex) and
// then drops busy with a one-cycle done pulse.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, begins a run from PC 0 (idle only)
//   imem_wen/waddr/wdata host memory write port (ignored while busy)
//   ins_valid, instr_if registered instruction offered downstream
//   halt_if             downstream stall; offered instruction not consumed
//   run_if              fetch stage active (RUN or DRAIN)
//   run_ex              execute unit still active
//   busy, done          micro running / one-cycle pulse when busy falls
//   pc_dbg              next read address
//
// Pipeline: a read request register (a_*), the synchronous memory output
// register (b_*), a one-entry skid buffer (s_*) and the output register (o_*).
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int           INSTRW   = 32,
  parameter int           IMSZLOG2 = 10,
  parameter logic [3:0]   END_OPC  = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                imem_wen,
  input  logic [IMSZLOG2-1:0] imem_waddr,
  input  logic [INSTRW-1:0]   imem_wdata,
  output logic                ins_valid,
  output logic [INSTRW-1:0]   instr_if,
  output logic                run_if,
  input  logic                halt_if,
  input  logic                run_ex,
  output logic                busy,
  output logic                done,
  output logic [IMSZLOG2-1:0] pc_dbg
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, WAIT_EX} state_e;

  localparam logic [IMSZLOG2-1:0] LAST_ADDR = '1;

  logic [INSTRW-1:0]   mem [2**IMSZLOG2];

  state_e              state_q, state_d;
  logic [IMSZLOG2-1:0] pc_q, pc_d;
  logic                a_v_q, a_v_d;
  logic [IMSZLOG2-1:0] a_addr_q, a_addr_d;
  logic                b_v_q, b_v_d;
  logic [INSTRW-1:0]   b_data_q;
  logic                s_v_q, s_v_d;
  logic [INSTRW-1:0]   s_data_q, s_data_d;
  logic                o_v_q, o_v_d;
  logic [INSTRW-1:0]   o_data_q, o_data_d;
  logic                done_q, done_d;

  logic halt_eff, b_end, b_fwd, b_hold, b_load, start_ok, issue_run, pipe_empty;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    o_v_d    = o_v_q;
    o_data_d = o_data_q;
    s_v_d    = s_v_q;
    s_data_d = s_data_q;
    a_v_d    = a_v_q;
    a_addr_d = a_addr_q;
    pc_d     = pc_q;
    b_hold   = 1'b0;

    // A stall only matters while something is actually offered.
    halt_eff = o_v_q & halt_if;
    // An END word sitting in the memory output is dropped, never forwarded.
    b_end    = b_v_q && (b_data_q[INSTRW-1 -: 4] == END_OPC);
    b_fwd    = b_v_q & ~b_end;

    if (!halt_eff) begin
      if (s_v_q) begin
        // Skid entry is older than the memory output, so it goes first.
        o_v_d    = 1'b1;
        o_data_d = s_data_q;
        s_v_d    = b_fwd;
        s_data_d = b_data_q;
      end else begin
        o_v_d    = b_fwd;
        o_data_d = b_data_q;
      end
    end else if (!s_v_q) begin
      s_v_d    = b_fwd;
      s_data_d = b_data_q;
    end else begin
      // Output and skid both full: the memory output register holds its word.
      b_hold = b_fwd;
    end

    start_ok  = (state_q == IDLE) & start;
    issue_run = (state_q == RUN) & ~b_end & ~halt_eff;

    if (start_ok) begin
      a_v_d    = 1'b1;
      a_addr_d = '0;
      pc_d     = IMSZLOG2'(1);
    end else if (b_end) begin
      a_v_d = 1'b0;                      // reads issued after END are discarded
    end else if (issue_run) begin
      a_v_d    = 1'b1;
      a_addr_d = pc_q;
      if (pc_q != LAST_ADDR) pc_d = pc_q + 1'b1;
    end else if (!b_hold) begin
      a_v_d = 1'b0;                      // request moved into the memory stage
    end

    b_load     = ~b_end & ~b_hold;
    b_v_d      = b_end ? 1'b0 : (b_hold ? b_v_q : a_v_q);
    pipe_empty = ~o_v_q & ~s_v_q & ~b_v_q & ~a_v_q;
    done_d     = (state_q == WAIT_EX) & ~run_ex;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (b_end)                                   state_d = DRAIN;
        else if (issue_run && pc_q == LAST_ADDR)     state_d = DRAIN;
      end
      DRAIN:   if (pipe_empty) state_d = WAIT_EX;
      WAIT_EX: if (!run_ex)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_if = (state_q == RUN) | (state_q == DRAIN);
    busy   = (state_q != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      a_v_q    <= 1'b0;
      a_addr_q <= '0;
      b_v_q    <= 1'b0;
      s_v_q    <= 1'b0;
      s_data_q <= '0;
      o_v_q    <= 1'b0;
      o_data_q <= '0;
      done_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      a_v_q    <= a_v_d;
      a_addr_q <= a_addr_d;
      b_v_q    <= b_v_d;
      s_v_q    <= s_v_d;
      s_data_q <= s_data_d;
      o_v_q    <= o_v_d;
      o_data_q <= o_data_d;
      done_q   <= done_d;
    end
  end

  // NOTE: the memory array and its read register carry no reset; program
  // contents survive reset and the read data is qualified by b_v_q.
  always_ff @(posedge clk) begin
    if (imem_wen && !busy) mem[imem_waddr] <= imem_wdata;
    if (b_load)            b_data_q <= mem[a_addr_q];
  end

  assign ins_valid = o_v_q;
  assign instr_if  = o_data_q;
  assign done      = done_q;
  assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch -- self-checking bench for instr_fetch (16-word memory).
// Expected streams come from a program array: words from address 0 up to the
// first END opcode, or all 16 words if there is none.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
  localparam int INSTRW = 32;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst, start, imem_wen, halt_if, run_ex;
  logic [AW-1:0]     imem_waddr, pc_dbg;
  logic [INSTRW-1:0] imem_wdata, instr_if;
  logic              ins_valid, run_if, busy, done;

  int checks   = 0;
  int failures = 0;

  logic [INSTRW-1:0] model_mem [DEPTH];
  logic [INSTRW-1:0] got_q [$];
  logic [INSTRW-1:0] exp_q [$];

  int first_valid, run_fall, done_cyc, done_cnt, busy_fall, last_consume;
  int valid_cycles, valid_rises, hold_cycles, max_pc, timed_out;
  bit pc_wrapped;

  instr_fetch #(.INSTRW(INSTRW), .IMSZLOG2(AW), .END_OPC(4'hF)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_wen(imem_wen),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .ins_valid(ins_valid),
    .instr_if(instr_if), .run_if(run_if), .halt_if(halt_if), .run_ex(run_ex),
    .busy(busy), .done(done), .pc_dbg(pc_dbg)
  );

  always #5 clk = ~clk;

  // Reference: program order up to (not including) the first END word.
  function automatic void build_expected();
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) begin
      if (model_mem[a][31:28] == 4'hF) break;
      exp_q.push_back(model_mem[a]);
    end
  endfunction

  function automatic bit stream_ok();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic write_word(input int addr, input logic [INSTRW-1:0] w);
    imem_wen   = 1'b1;
    imem_waddr = addr[AW-1:0];
    imem_wdata = w;
    model_mem[addr] = w;
    @(negedge clk);
    imem_wen = 1'b0;
  endtask

  task automatic load_basic();
    write_word(0, 32'h10000001);
    write_word(1, 32'h10000002);
    write_word(2, 32'h10000003);
    write_word(3, 32'hF0000000);
    for (int a = 4; a < DEPTH; a++) write_word(a, 32'h20000000 + a);
  endtask

  // One run from a start pulse until two cycles after done (or a cycle budget).
  // Sample index cyc = k means "just after edge Ek", E0 being the start edge.
  task automatic do_run(input int halt_pct, input logic [INSTRW-1:0] halt_word,
                        input int ex_hold, input bit poke,
                        input logic [INSTRW-1:0] poke_word);
    int cyc, halt_left;
    bit halted_once, prev_valid;
    logic [AW-1:0] prev_pc;
    got_q.delete();
    first_valid = -1; run_fall = -1; done_cyc = -1; done_cnt = 0;
    busy_fall = -1; last_consume = -1; valid_cycles = 0; valid_rises = 0;
    hold_cycles = 0; max_pc = 0; timed_out = 0; pc_wrapped = 1'b0;
    cyc = -1; halt_left = 0; halted_once = 1'b0; prev_valid = 1'b0; prev_pc = '0;
    start  = 1'b1;
    run_ex = (ex_hold > 0);
    forever begin
      @(negedge clk);
      cyc++;
      start    = 1'b0;
      imem_wen = 1'b0;
      if (ins_valid) valid_cycles++;
      if (ins_valid && !prev_valid) valid_rises++;
      prev_valid = ins_valid;
      if (ins_valid && first_valid < 0) first_valid = cyc;
      if (!run_if && run_fall < 0) run_fall = cyc;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (!busy && busy_fall < 0) busy_fall = cyc;
      if (pc_dbg < prev_pc) pc_wrapped = 1'b1;
      prev_pc = pc_dbg;
      if (int'(pc_dbg) > max_pc) max_pc = int'(pc_dbg);
      if (ins_valid && instr_if === halt_word && halt_word != '0) hold_cycles++;
      if (!halted_once && ins_valid && instr_if === halt_word && halt_word != '0) begin
        halted_once = 1'b1;
        halt_left   = 3;
      end
      if (halt_left > 0) begin
        halt_if = 1'b1;
        halt_left--;
      end else begin
        halt_if = (int'($urandom_range(99)) < halt_pct);
      end
      if (ins_valid && !halt_if) begin
        got_q.push_back(instr_if);
        last_consume = cyc + 1;
      end
      run_ex = (ex_hold > 0) && (run_fall < 0 || cyc < run_fall + ex_hold);
      if (poke && cyc == 3) begin
        start      = 1'b1;
        imem_wen   = 1'b1;
        imem_waddr = 4'd1;
        imem_wdata = poke_word;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc >= 400) begin timed_out = 1; break; end
    end
    halt_if = 1'b0; run_ex = 1'b0; start = 1'b0; imem_wen = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; imem_wen = 1'b0; imem_waddr = '0; imem_wdata = '0;
    halt_if = 1'b0; run_ex = 1'b0;
    #12;
    checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL reset_ins_valid: got %b expected 0", ins_valid); end
    checks++; if (instr_if !== '0) begin failures++; $display("FAIL reset_instr_if: got %h expected 0", instr_if); end
    checks++; if (run_if !== 1'b0) begin failures++; $display("FAIL reset_run_if: got %b expected 0", run_if); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (pc_dbg !== '0) begin failures++; $display("FAIL reset_pc_dbg: got %0d expected 0", pc_dbg); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_stream();
    load_basic();
    build_expected();
    do_run(0, '0, 0, 1'b0, '0);
    checks++; if (timed_out != 0) begin failures++; $display("FAIL basic_timeout: got %0d expected 0", timed_out); end
    checks++; if (!stream_ok()) begin failures++; $display("FAIL basic_stream: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (first_valid != 2) begin failures++; $display("FAIL basic_latency: got %0d expected 2", first_valid); end
    checks++; if (valid_cycles != 3) begin failures++; $display("FAIL basic_valid_cycles: got %0d expected 3", valid_cycles); end
    checks++; if (run_fall != last_consume + 1) begin failures++; $display("FAIL basic_run_if_fall: got %0d expected %0d", run_fall, last_consume + 1); end
    checks++; if (done_cyc != run_fall + 1) begin failures++; $display("FAIL basic_done_time: got %0d expected %0d", done_cyc, run_fall + 1); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (busy_fall != done_cyc) begin failures++; $display("FAIL basic_busy_fall: got %0d expected %0d", busy_fall, done_cyc); end
  endtask

  task automatic test_stall();
    build_expected();
    do_run(0, 32'h10000002, 0, 1'b0, '0);
    checks++; if (!stream_ok()) begin failures++; $display("FAIL stall_stream: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (hold_cycles != 4) begin failures++; $display("FAIL stall_hold: got %0d cycles expected 4", hold_cycles); end
    checks++; if (valid_rises != 1) begin failures++; $display("FAIL stall_gap: got %0d valid bursts expected 1", valid_rises); end
    checks++; if (valid_cycles != 6) begin failures++; $display("FAIL stall_valid_cycles: got %0d expected 6", valid_cycles); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL stall_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_wait_ex();
    build_expected();
    do_run(0, '0, 10, 1'b0, '0);
    checks++; if (!stream_ok()) begin failures++; $display("FAIL waitex_stream: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (done_cyc != run_fall + 11) begin failures++; $display("FAIL waitex_done_time: got %0d expected %0d", done_cyc, run_fall + 11); end
    checks++; if (busy_fall != done_cyc) begin failures++; $display("FAIL waitex_busy_fall: got %0d expected %0d", busy_fall, done_cyc); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL waitex_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_ignored_while_busy();
    build_expected();
    do_run(0, '0, 0, 1'b1, 32'hDEADBEEF);
    checks++; if (!stream_ok()) begin failures++; $display("FAIL ignored_stream: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL ignored_done: got %0d expected 1", done_cnt); end
    do_run(0, '0, 0, 1'b0, '0);
    checks++; if (!stream_ok()) begin failures++; $display("FAIL ignored_readback: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() > 1 && got_q[1] !== 32'h10000002) begin failures++; $display("FAIL ignored_word1: got %h expected 10000002", got_q[1]); end
  endtask

  task automatic test_end_at_zero();
    write_word(0, 32'hF1234567);
    build_expected();
    do_run(20, '0, 0, 1'b0, '0);
    checks++; if (valid_cycles != 0) begin failures++; $display("FAIL end0_valid: got %0d expected 0", valid_cycles); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL end0_done: got %0d expected 1", done_cnt); end
    checks++; if (timed_out != 0) begin failures++; $display("FAIL end0_timeout: got %0d expected 0", timed_out); end
  endtask

  task automatic test_no_end();
    for (int a = 0; a < DEPTH; a++) write_word(a, 32'h30000000 + (a * 32'h111));
    build_expected();
    do_run(30, '0, 2, 1'b0, '0);
    checks++; if (got_q.size() != 16) begin failures++; $display("FAIL noend_count: got %0d expected 16", got_q.size()); end
    checks++; if (!stream_ok()) begin failures++; $display("FAIL noend_stream: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (pc_wrapped) begin failures++; $display("FAIL noend_wrap: got 1 expected 0"); end
    checks++; if (pc_dbg !== 4'd15) begin failures++; $display("FAIL noend_final_pc: got %0d expected 15", pc_dbg); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL noend_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    for (int a = 0; a < DEPTH; a++) write_word(a, (a == 9) ? 32'hF0000009 : 32'h40000000 + a);
    build_expected();
    done_seen = 0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({ins_valid, run_if, busy, done} !== 4'b0000) begin failures++; $display("FAIL midreset_flags: got %b expected 0000", {ins_valid, run_if, busy, done}); end
    checks++; if (instr_if !== '0 || pc_dbg !== '0) begin failures++; $display("FAIL midreset_data: got instr %h pc %0d expected 0 0", instr_if, pc_dbg); end
    repeat (3) begin @(negedge clk); if (done) done_seen++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (done) done_seen++; end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL midreset_done: got %0d pulses expected 0", done_seen); end
    do_run(0, '0, 0, 1'b0, '0);
    checks++; if (!stream_ok()) begin failures++; $display("FAIL midreset_replay: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (first_valid != 2) begin failures++; $display("FAIL midreset_latency: got %0d expected 2", first_valid); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int end_at;
      end_at = int'($urandom_range(16));
      for (int a = 0; a < DEPTH; a++) begin
        logic [INSTRW-1:0] w;
        w = $urandom();
        w[31:28] = (a == end_at) ? 4'hF : 4'($urandom_range(14));
        write_word(a, w);
      end
      build_expected();
      do_run(int'($urandom_range(60)), '0, int'($urandom_range(5)), 1'b0, '0);
      checks++; if (!stream_ok()) begin failures++; $display("FAIL random_stream[%0d]: got %0d words expected %0d", it, got_q.size(), exp_q.size()); end
      checks++; if (done_cnt != 1 || timed_out != 0) begin failures++; $display("FAIL random_done[%0d]: got %0d pulses timeout %0d expected 1 0", it, done_cnt, timed_out); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_stall();
    test_wait_ex();
    test_ignored_while_busy();
    test_end_at_zero();
    test_no_end();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
